// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES carry-registered slices.
// Each stage adds one CHUNK = WIDTH/STAGES slice. Unconsumed upper operand
// slices travel in delay registers, and finished lower sum slices travel
// alongside them, so sum/cout/ovf leave the last stage aligned.
// Optional feature: define PIPELINED_ADDER_SUB_EN to add the in_sub port
// (a - b computed as a + ~b + 1, cin ignored).
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready; an output transfer happens where out_valid && out_ready.
// The whole pipe advances when (!out_valid || out_ready); in_ready equals that
// advance term and never looks at in_valid. While stalled every stage, and
// therefore sum/cout/ovf, holds its value.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             msb_carry_in;
  logic             ovf_d;
  logic             ovf_q;

  // Operand conditioning: subtraction is addition of the inverted b with carry 1.
`ifdef PIPELINED_ADDER_SUB_EN
  assign b_in = in_sub ? ~b : b;
  assign c_in = in_sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Delay registers for operand slices not yet consumed by an adder stage.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_ops
    localparam int OW = WIDTH - (k + 1) * CHUNK;
    logic [OW-1:0] a_d, b_d, a_q, b_q;

    if (k == 0) begin : g_src
      assign a_d = a[WIDTH-1:CHUNK];
      assign b_d = b_in[WIDTH-1:CHUNK];
    end else begin : g_src
      assign a_d = g_ops[k-1].a_q[OW+CHUNK-1:CHUNK];
      assign b_d = g_ops[k-1].b_q[OW+CHUNK-1:CHUNK];
    end

    // Upper operand slices shift with the pipe and hold on stall.
    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else if (advance) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  // Adder stages: slice add, carry register, accumulated lower sum and valid bit.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0]         sl_a, sl_b;
    logic                     c_in_s, v_in_s;
    logic [CHUNK:0]           part;
    logic [(k+1)*CHUNK-1:0]   s_d, s_q;
    logic                     c_q, v_q;

    if (k == 0) begin : g_src
      assign sl_a   = a[CHUNK-1:0];
      assign sl_b   = b_in[CHUNK-1:0];
      assign c_in_s = c_in;
      assign v_in_s = in_valid;
      assign s_d    = part[CHUNK-1:0];
    end else begin : g_src
      assign sl_a   = g_ops[k-1].a_q[CHUNK-1:0];
      assign sl_b   = g_ops[k-1].b_q[CHUNK-1:0];
      assign c_in_s = g_stage[k-1].c_q;
      assign v_in_s = g_stage[k-1].v_q;
      assign s_d    = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign part = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, c_in_s};

    // Stage register: shift sum/carry/valid on advance, hold otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in_s;
        c_q <= part[CHUNK];
        s_q <= s_d;
      end
    end
  end

  // Signed overflow: carry into the MSB (recovered from the MSB sum bit) xor carry out.
  assign msb_carry_in = g_stage[STAGES-1].sl_a[CHUNK-1] ^
                        g_stage[STAGES-1].sl_b[CHUNK-1] ^
                        g_stage[STAGES-1].part[CHUNK-1];
  assign ovf_d        = msb_carry_in ^ g_stage[STAGES-1].part[CHUNK];

  // Overflow flag registered alongside the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand and sum width in bits; SHALL be at least 1.
REQ-002 Parameter: STAGES, default 4, number of pipeline stages; SHALL be between 1 and WIDTH, with WIDTH divisible by STAGES.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in_valid, input, 1 bit: the operand set on a, b and cin is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operand set this cycle.
REQ-007 Port a, input, WIDTH bits: first operand.
REQ-008 Port b, input, WIDTH bits: second operand.
REQ-009 Port cin, input, 1 bit: carry input.
REQ-010 Port out_valid, output, 1 bit: sum, cout and ovf hold a valid result.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-012 Port sum, output, WIDTH bits: result bits.
REQ-013 Port cout, output, 1 bit: carry out of the MSB.
REQ-014 Port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 Each stage SHALL add one CHUNK = WIDTH/STAGES bit slice and register the slice carry into the next stage; upper operand slices are delay-registered and lower sum slices are skew-registered so that the outputs are aligned.
REQ-016 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); ovf = carry into MSB XOR cout.
REQ-017 Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-018 Stall: advance = !out_valid || out_ready; in_ready = advance, with no combinational dependence on in_valid.
REQ-019 When advance=1, every stage SHALL shift one position and its valid bit SHALL shift with it; when advance=0, all stages and outputs SHALL hold.
REQ-020 Latency: a result accepted in cycle N SHALL reach the outputs in cycle N+STAGES when no stall occurs; each stall cycle adds one cycle.
REQ-021 Throughput: the block SHALL accept one operand set per cycle while out_ready=1.
REQ-022 Bubbles (in_valid=0 while advance=1) SHALL propagate as invalid stages and SHALL NOT be compacted.
REQ-023 Results SHALL leave in acceptance order; no result SHALL be lost or duplicated under arbitrary out_ready patterns.
REQ-024 sum, cout and ovf SHALL be stable while out_valid && !out_ready.
REQ-025 STAGES=1: the block is a single registered adder with latency 1.
REQ-026 Wrap-around: all-ones + all-ones + 1 SHALL give sum = all-ones and cout = 1.

Reset
REQ-027 When rst=1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and sum, cout and ovf SHALL clear to 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset.
REQ-029 Reset mid-operation SHALL discard all in-flight results, and no stale result SHALL appear afterwards.
REQ-030 During reset, an input transfer SHALL be ignored even if in_valid=1.

Configuration
REQ-031 Macro PIPELINED_ADDER_SUB_EN, when defined, SHALL add a port in_sub (input, 1 bit) that is captured with the operands.
REQ-032 With the macro defined and in_sub=1, the block SHALL compute a + ~b + 1 and ignore cin; cout=1 means no borrow, and ovf is the signed subtract overflow.
REQ-033 Without the macro, the in_sub port SHALL NOT exist and the block is add-only per REQ-016.

Verification (WIDTH=32, STAGES=4)
REQ-034 Apply a=0x0000_0001, b=0x0000_0002, cin=1 with out_ready=1 -> out_valid high 4 cycles later with sum=0x0000_0004, cout=0, ovf=0.
REQ-035 Apply a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, ovf=0, covering full carry propagation across all slices; then a=0x7FFF_FFFF, b=1, cin=0 -> sum=0x8000_0000, cout=0, ovf=1.
REQ-036 Stream 16 back-to-back random operand sets with out_ready=1 -> 16 consecutive correct results starting 4 cycles after the first acceptance, with in_ready constantly 1.
REQ-037 Stream 8 operand sets with out_ready toggling in a 3-low/2-high pattern and random input bubbles -> results in order, none lost or duplicated, outputs stable during each stall.
REQ-038 Assert rst for one cycle with 3 results in flight -> out_valid=0 in the next cycle and no old result appears afterwards; in_ready=1.
REQ-039 With PIPELINED_ADDER_SUB_EN defined: a=5, b=7, in_sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; a=0x8000_0000, b=1, in_sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1.
